// File: rtl/rdyacpt_elastic_fifo.sv
// rdyacpt_elastic_fifo: parametrised-depth ready/accept elastic buffer.
// Decouples interleaver datapath stages. It reports the fill level, raises an
// almost-full flag and supports a synchronous flush.
// Optional feature macro: RDYACPT_BYPASS_EN. When it is defined, a word takes a
// zero-latency cut-through path while the buffer is empty.
// Without the macro, upstream_acpt and downstream_rdy depend only on registered
// state and on flush.
module rdyacpt_elastic_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       upstream_rdy,
    input  logic [WIDTH-1:0]           upstream_data,
    output logic                       upstream_acpt,
    output logic                       downstream_rdy,
    output logic [WIDTH-1:0]           downstream_data,
    input  logic                       downstream_acpt,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;
`ifdef RDYACPT_BYPASS_EN
    logic             bypass;
`endif

    // Handshake decode. A full buffer refuses a push even when a pop happens in
    // the same cycle, so upstream_acpt never depends on downstream_acpt.
    always_comb begin
        not_full  = (level_q != FULL_LVL);
        not_empty = (level_q != '0);
`ifdef RDYACPT_BYPASS_EN
        bypass          = (level_q == '0) & ~flush & downstream_acpt;
        upstream_acpt   = ~flush & (not_full | bypass);
        downstream_rdy  = bypass ? upstream_rdy : (~flush & not_empty);
        downstream_data = bypass ? upstream_data : mem[rd_ptr];
        push            = upstream_rdy & upstream_acpt;
        pop             = downstream_rdy & downstream_acpt;
        wr_en           = push & ~bypass;
        rd_en           = pop & ~bypass;
`else
        upstream_acpt   = ~flush & not_full;
        downstream_rdy  = ~flush & not_empty;
        downstream_data = mem[rd_ptr];
        push            = upstream_rdy & upstream_acpt;
        pop             = downstream_rdy & downstream_acpt;
        wr_en           = push;
        rd_en           = pop;
`endif
        level       = level_q;
        almost_full = (level_q >= AF_LVL);
    end

    // Storage, pointers and level. Flush rewinds the buffer but leaves the
    // stored words in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= upstream_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
